// File: rtl/rom_burst_pkg.sv
// Shared types and default sizes for the ROM burst reader.
package rom_burst_pkg;

  localparam int ADDR_W_DEF = 2;
  localparam int DATA_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/rom_burst_skid.sv
// Two-entry FIFO carrying {last, data} from the ROM to the output stream.
// The head entry registers drive m_data/m_last/m_valid directly.
module rom_burst_skid
  import rom_burst_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              push_last,
  input  logic              pop,
  output logic [1:0]        occ,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  output logic              m_last
);

  logic [DATA_W:0] head_q;
  logic [DATA_W:0] tail_q;
  logic            head_vld;
  logic            tail_vld;
  logic [DATA_W:0] push_word;

  assign push_word = {push_last, push_data};
  assign occ       = {1'b0, head_vld} + {1'b0, tail_vld};
  assign m_data    = head_q[DATA_W-1:0];
  assign m_last    = head_q[DATA_W];
  assign m_valid   = head_vld;

  // FIFO update: pop shifts tail into head; push fills the first free slot.
  // NOTE: these entries are output registers with defined reset values, so they
  // are reset along with the valid bits rather than left as unreset storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q   <= '0;
      tail_q   <= '0;
      head_vld <= 1'b0;
      tail_vld <= 1'b0;
    end else if (pop) begin
      if (tail_vld) begin
        head_q   <= tail_q;
        head_vld <= 1'b1;
        tail_vld <= push;
        if (push) tail_q <= push_word;
      end else begin
        head_vld <= push;
        if (push) head_q <= push_word;
      end
    end else if (push) begin
      if (!head_vld) begin
        head_q   <= push_word;
        head_vld <= 1'b1;
      end else begin
        tail_q   <= push_word;
        tail_vld <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/rom_burst_reader.sv
// Turns a start command into a burst of synchronous-ROM reads and streams the
// returned words through a 2-entry buffer with valid/ready backpressure.
module rom_burst_reader
  import rom_burst_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last
);

  localparam int              DEPTH   = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_V   = (ADDR_W + 1)'(1);

  state_t            state;
  logic [ADDR_W-1:0] addr_cnt;
  logic [ADDR_W:0]   remaining;
  logic              rd_pend;
  logic              rd_last;
  logic [1:0]        occ;
  logic              pop;
  logic [2:0]        slots;
  logic              issue;
  logic              final_issue;

  assign rom_addr = addr_cnt;
  assign busy     = (state != IDLE);

  // Issue a read whenever the buffer plus the in-flight read leaves room.
  // NOTE: every signal gets a default at the top so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    pop         = 1'b0;
    slots       = '0;
    issue       = 1'b0;
    final_issue = 1'b0;
    pop         = m_valid & m_ready;
    slots       = {1'b0, occ} + {2'b0, rd_pend} - {2'b0, pop};
    issue       = (state == RUN) && (remaining != '0) && (slots < 3'd2);
    final_issue = issue && (remaining == ONE_V);
  end

  // Burst FSM with address counter, remaining count and ROM latency tracking.
  // NOTE: non-blocking assignments keep every register reading the values from
  // before the edge, regardless of statement order in this block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr_cnt  <= '0;
      remaining <= '0;
      rd_pend   <= 1'b0;
      rd_last   <= 1'b0;
      done      <= 1'b0;
    end else begin
      done    <= 1'b0;
      rd_pend <= issue;
      rd_last <= final_issue;
      if (issue) begin
        addr_cnt  <= addr_cnt + 1'b1;
        remaining <= remaining - 1'b1;
      end
      case (state)
        IDLE: begin
          if (start) begin
            if (count == '0) begin
              done <= 1'b1;
            end else begin
              state     <= RUN;
              addr_cnt  <= start_addr;
              remaining <= (count > DEPTH_V) ? DEPTH_V : count;
            end
          end
        end
        RUN: begin
          if (final_issue) state <= DRAIN;
        end
        DRAIN: begin
          if (pop && m_last) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  rom_burst_skid #(
    .DATA_W(DATA_W)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (rd_pend),
    .push_data(rom_data),
    .push_last(rd_last),
    .pop      (pop),
    .occ      (occ),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_last   (m_last)
  );

endmodule
